// File: rtl/xor_cipher_pkg.sv
// Shared types and defaults for the XOR cipher control path.
package xor_cipher_pkg;

  localparam int KEY_BITS_DEF = 32;
  localparam int MSG_BITS_DEF = 512;
  localparam int TIMEOUT_DEF  = 2048;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_MSG,
    S_WAIT_ENC,
    S_WAIT_SER,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP      = 2'b00,
    CMD_LOAD_KEY = 2'b01,
    CMD_LOAD_MSG = 2'b10,
    CMD_ENCRYPT  = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ORDER   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_RSVD    = 2'b11
  } err_t;

endpackage

// File: rtl/seq_bit_counter.sv
// Terminal-count counter: clears, counts when enabled, saturates at term.
module seq_bit_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == term);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Command sequencer for the XOR cipher datapath: load gating,
// encrypt start, completion tracking and timeout reporting.
module xor_cipher_sequencer
  import xor_cipher_pkg::*;
#(
  parameter int KEY_BITS = KEY_BITS_DEF,
  parameter int MSG_BITS = MSG_BITS_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       iCmd_valid,
  input  logic [1:0] iCmd,
  input  logic       iAbort,
  input  logic       iEncrypt_done,
  input  logic       iSerial_end,
  output logic       oCmd_ready,
  output logic       oLoad_key,
  output logic       oLoad_msg,
  output logic       oStart_enc,
  output logic       oBusy,
  output logic       oKey_loaded,
  output logic       oMsg_loaded,
  output logic [1:0] oErr_code
);

  localparam int CNT_W = $clog2(MSG_BITS) + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t state, state_n;
  err_t   err_q, err_n;
  logic   key_q, key_n;
  logic   msg_q, msg_n;
  logic   start_q, start_n;
  logic   accept;

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_term;
  logic             bit_tc;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_tc;

  assign oCmd_ready  = (state == S_IDLE) && ena;
  assign oLoad_key   = (state == S_LOAD_KEY);
  assign oLoad_msg   = (state == S_LOAD_MSG);
  assign oStart_enc  = start_q;
  assign oBusy       = (state != S_IDLE) && (state != S_ERROR);
  assign oKey_loaded = key_q;
  assign oMsg_loaded = msg_q;
  assign oErr_code   = err_q;

  assign accept   = iCmd_valid && oCmd_ready && !iAbort;
  assign bit_term = (state == S_LOAD_MSG) ? MSG_LAST : KEY_LAST;

  seq_bit_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ena && (state == S_IDLE)),
    .en    (ena && (oLoad_key || oLoad_msg)),
    .term  (bit_term),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  // Timer restarts on entry to each wait state.
  seq_bit_counter #(.W(TMR_W)) u_tmr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ena && ((state == S_IDLE) ||
            ((state == S_WAIT_ENC) && iEncrypt_done))),
    .en    (ena && ((state == S_WAIT_ENC) ||
            (state == S_WAIT_SER))),
    .term  (TMR_LAST),
    .count (tmr_cnt),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_n = state;
    err_n   = err_q;
    key_n   = key_q;
    msg_n   = msg_q;
    start_n = 1'b0;
    if (iAbort) begin
      state_n = S_IDLE;
      err_n   = ERR_NONE;
      key_n   = 1'b0;
      msg_n   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            err_n = ERR_NONE;
            unique case (cmd_t'(iCmd))
              CMD_LOAD_KEY: begin
                state_n = S_LOAD_KEY;
                key_n   = 1'b0;
              end
              CMD_LOAD_MSG: begin
                state_n = S_LOAD_MSG;
                msg_n   = 1'b0;
              end
              CMD_ENCRYPT: begin
                if (key_q && msg_q) begin
                  state_n = S_WAIT_ENC;
                  start_n = 1'b1;
                end else begin
                  state_n = S_ERROR;
                  err_n   = ERR_ORDER;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD_KEY: begin
          if (bit_tc) begin
            state_n = S_IDLE;
            key_n   = 1'b1;
          end
        end
        S_LOAD_MSG: begin
          if (bit_tc) begin
            state_n = S_IDLE;
            msg_n   = 1'b1;
          end
        end
        S_WAIT_ENC: begin
          if (iEncrypt_done) begin
            state_n = S_WAIT_SER;
          end else if (tmr_tc) begin
            state_n = S_ERROR;
            err_n   = ERR_TIMEOUT;
          end
        end
        S_WAIT_SER: begin
          if (iSerial_end) begin
            state_n = S_IDLE;
            msg_n   = 1'b0;
          end else if (tmr_tc) begin
            state_n = S_ERROR;
            err_n   = ERR_TIMEOUT;
          end
        end
        S_ERROR: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ena low freezes every register, abort included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      err_q   <= ERR_NONE;
      key_q   <= 1'b0;
      msg_q   <= 1'b0;
      start_q <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      err_q   <= err_n;
      key_q   <= key_n;
      msg_q   <= msg_n;
      start_q <= start_n;
    end
  end

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Self-checking bench for xor_cipher_sequencer: vector table,
// directed multi-cycle sequences and randomized transactions.
module tb_xor_cipher_sequencer;

  localparam int KEY_BITS = 32;
  localparam int MSG_BITS = 512;
  localparam int TIMEOUT  = 2048;
  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_KEY = 2'b01;
  localparam logic [1:0] C_MSG = 2'b10;
  localparam logic [1:0] C_ENC = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       iCmd_valid = 1'b0;
  logic [1:0] iCmd = 2'b00;
  logic       iAbort = 1'b0;
  logic       iEncrypt_done = 1'b0;
  logic       iSerial_end = 1'b0;
  logic       oCmd_ready, oLoad_key, oLoad_msg, oStart_enc;
  logic       oBusy, oKey_loaded, oMsg_loaded;
  logic [1:0] oErr_code;

  int checks = 0;
  int errors = 0;

  xor_cipher_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .iCmd_valid    (iCmd_valid),
    .iCmd          (iCmd),
    .iAbort        (iAbort),
    .iEncrypt_done (iEncrypt_done),
    .iSerial_end   (iSerial_end),
    .oCmd_ready    (oCmd_ready),
    .oLoad_key     (oLoad_key),
    .oLoad_msg     (oLoad_msg),
    .oStart_enc    (oStart_enc),
    .oBusy         (oBusy),
    .oKey_loaded   (oKey_loaded),
    .oMsg_loaded   (oMsg_loaded),
    .oErr_code     (oErr_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       valid;
    logic       abort;
    logic [1:0] cmd;
    logic [8:0] exp;
  } vec_t;

  function automatic logic [8:0] obs();
    return {oCmd_ready, oLoad_key, oLoad_msg, oStart_enc,
            oBusy, oKey_loaded, oMsg_loaded, oErr_code};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] cmd);
    iCmd_valid = 1'b1;
    iCmd = cmd;
    cyc();
    iCmd_valid = 1'b0;
    iCmd = C_NOP;
  endtask

  task automatic abort_now();
    iAbort = 1'b1;
    cyc();
    iAbort = 1'b0;
  endtask

  task automatic load_run(input bit rnd, input int gs, input int gl,
                          output int hi, output int n);
    hi = 0;
    n = 0;
    while (oBusy && n < 4000) begin
      if (rnd) ena = ($urandom_range(3) != 0);
      else ena = !(n >= gs && n < gs + gl);
      if ((oLoad_key || oLoad_msg) && ena) hi++;
      cyc();
      n++;
    end
    ena = 1'b1;
  endtask

  task automatic enc_run(input int d, input int s,
                         output int starts, output int n);
    starts = 0;
    n = 0;
    while (oBusy && n < 5000) begin
      if (oStart_enc) starts++;
      iEncrypt_done = (n == d);
      iSerial_end = (s >= 0 && n == d + s);
      cyc();
      n++;
    end
    iEncrypt_done = 1'b0;
    iSerial_end = 1'b0;
  endtask

  vec_t vecs[12];
  int hi, n, st, k;
  bit key_m, msg_m;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, C_NOP, 9'b1_0000_00_00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, C_NOP, 9'b1_0000_00_00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, C_ENC, 9'b0_0000_00_01};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, C_KEY, 9'b0_0000_00_01};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, C_NOP, 9'b0_0000_00_01};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, C_KEY, 9'b1_0000_00_00};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, C_MSG, 9'b0_0101_00_00};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, C_NOP, 9'b0_0101_00_00};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, C_KEY, 9'b1_0000_00_00};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, C_NOP, 9'b1_0000_00_00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, C_KEY, 9'b0_1001_00_00};
    vecs[11] = '{1'b1, 1'b0, 1'b1, C_NOP, 9'b1_0000_00_00};

    repeat (3) cyc();
    chk("reset_outputs", obs(), 9'b1_0000_00_00);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 12; i++) begin
      ena = vecs[i].ena;
      iCmd_valid = vecs[i].valid;
      iAbort = vecs[i].abort;
      iCmd = vecs[i].cmd;
      cyc();
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    ena = 1'b1;
    iCmd_valid = 1'b0;
    iAbort = 1'b0;
    iCmd = C_NOP;

    issue(C_KEY);
    load_run(1'b0, 0, 0, hi, n);
    chk("t1_key_high_cycles", hi, KEY_BITS);
    chk("t1_key_loaded", oKey_loaded, 1);
    chk("t1_cmd_ready", oCmd_ready, 1);

    issue(C_MSG);
    load_run(1'b0, 100, 10, hi, n);
    chk("t2_msg_high_cycles", hi, MSG_BITS);
    chk("t2_msg_total_cycles", n, MSG_BITS + 10);
    chk("t2_msg_loaded", oMsg_loaded, 1);
    chk("t2_key_kept", oKey_loaded, 1);

    abort_now();
    issue(C_KEY);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_ENC);
    chk("t3_err_order", oErr_code, 1);
    chk("t3_not_busy", oBusy, 0);
    chk("t3_not_ready", oCmd_ready, 0);
    abort_now();
    chk("t3_abort_state", obs(), 9'b1_0000_00_00);

    issue(C_KEY);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_MSG);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_ENC);
    enc_run(5, 600, st, n);
    chk("t4_start_pulses", st, 1);
    chk("t4_cycles", n, 606);
    chk("t4_end_state", obs(), 9'b1_0000_10_00);

    issue(C_MSG);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_ENC);
    enc_run(-1, -1, st, n);
    chk("t5_timeout_cycles", n, TIMEOUT);
    chk("t5_err_timeout", oErr_code, 2);
    chk("t5_not_busy", oBusy, 0);
    abort_now();

    issue(C_KEY);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_MSG);
    repeat (20) cyc();
    iAbort = 1'b1;
    iCmd_valid = 1'b1;
    iCmd = C_KEY;
    cyc();
    iAbort = 1'b0;
    iCmd_valid = 1'b0;
    iCmd = C_NOP;
    chk("t6_abort_state", obs(), 9'b1_0000_00_00);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (oLoad_key) hi++;
      cyc();
    end
    chk("t6_no_key_load", hi, 0);
    issue(C_KEY);
    load_run(1'b0, 0, 0, hi, n);
    issue(C_MSG);
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    chk("t6_reset_mid_load", obs(), 9'b1_0000_00_00);
    rst_n = 1'b1;
    cyc();

    key_m = 1'b0;
    msg_m = 1'b0;
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(3))
        0: begin
          issue(C_KEY);
          load_run(1'b1, 0, 0, hi, n);
          chk($sformatf("r%0d_key_bits", it), hi, KEY_BITS);
          key_m = 1'b1;
        end
        1: begin
          issue(C_MSG);
          load_run(1'b1, 0, 0, hi, n);
          chk($sformatf("r%0d_msg_bits", it), hi, MSG_BITS);
          msg_m = 1'b1;
        end
        2: begin
          issue(C_ENC);
          if (key_m && msg_m) begin
            enc_run($urandom_range(40, 1), $urandom_range(700, 1), st, n);
            chk($sformatf("r%0d_starts", it), st, 1);
            msg_m = 1'b0;
          end else begin
            chk($sformatf("r%0d_err_order", it), oErr_code, 1);
            abort_now();
            key_m = 1'b0;
            msg_m = 1'b0;
          end
        end
        default: begin
          issue($urandom_range(1) != 0 ? C_KEY : C_MSG);
          k = $urandom_range(30, 1);
          repeat (k) cyc();
          abort_now();
          chk($sformatf("r%0d_gates_off", it),
              {oLoad_key, oLoad_msg}, 0);
          key_m = 1'b0;
          msg_m = 1'b0;
        end
      endcase
      chk($sformatf("r%0d_flags", it),
          {oKey_loaded, oMsg_loaded, oErr_code, oCmd_ready},
          {key_m, msg_m, 2'b00, 1'b1});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
